// File: rtl/radix_convert_seq.sv
// radix_convert_seq: multi-cycle handshaked converter that turns one operand
// into hex, octal, BCD or raw 4-bit digit nibbles. It also reports the sign,
// the significant-digit count and overflow.
module radix_convert_seq #(
    parameter int WIDTH = 32,
    parameter int NDIG  = 11
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    input  logic [1:0]                  in_mode,
    input  logic                        in_signed,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [4*NDIG-1:0]           out_digits,
    output logic                        out_neg,
    output logic [$clog2(NDIG+1)-1:0]   out_ndig,
    output logic                        out_ovf
);

    localparam int ACCW   = 4 * NDIG;
    localparam int NDW    = $clog2(NDIG + 1);
    localparam int CW     = $clog2(WIDTH + NDIG + 1);
    localparam int HEXCYC = (WIDTH + 3) / 4;
    localparam int OCTCYC = (WIDTH + 2) / 3;

    localparam logic [CW-1:0] DEC_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] HEX_LAST = CW'(HEXCYC - 1);
    localparam logic [CW-1:0] OCT_LAST = CW'(OCTCYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_HEX = 2'b00,
        MODE_OCT = 2'b01,
        MODE_DEC = 2'b10,
        MODE_RAW = 2'b11
    } mode_t;

    state_t             state_q, state_d;
    mode_t              mode_q,  mode_d;
    logic [WIDTH-1:0]   work_q,  work_d;
    logic [ACCW-1:0]    acc_q,   acc_d;
    logic               neg_q,   neg_d;
    logic [NDW-1:0]     ndig_q,  ndig_d;
    logic               ovf_q,   ovf_d;
    logic [CW-1:0]      cnt_q,   cnt_d;

    logic [WIDTH+ACCW-1:0] rawExt;
    logic [ACCW-1:0]       dabbled;
    logic [3:0]            digit;
    logic                  placed;
    logic                  lastStep;

    // Count of significant digits: one plus the index of the top nonzero nibble.
    function automatic logic [NDW-1:0] calcNdig(input logic [ACCW-1:0] d);
        logic [NDW-1:0] n;
        n = NDW'(1);
        for (int i = 0; i < NDIG; i++) begin
            if (d[4*i +: 4] != 4'd0) begin
                n = NDW'(i + 1);
            end
        end
        return n;
    endfunction

    // Next-state logic: accept an operand, step the conversion and run the result handshake.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        work_d    = work_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        ndig_d    = ndig_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rawExt    = {{ACCW{1'b0}}, in_data};
        dabbled   = acc_q;
        digit     = 4'd0;
        placed    = 1'b0;
        lastStep  = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mode_d = mode_t'(in_mode);
                    cnt_d  = '0;
                    acc_d  = '0;
                    ovf_d  = 1'b0;
                    neg_d  = 1'b0;
                    work_d = in_data;
                    if (mode_d == MODE_DEC && in_signed && in_data[WIDTH-1]) begin
                        neg_d  = 1'b1;
                        work_d = -in_data;
                    end
                    if (mode_d == MODE_RAW) begin
                        acc_d   = rawExt[ACCW-1:0];
                        ovf_d   = |rawExt[WIDTH+ACCW-1:ACCW];
                        ndig_d  = calcNdig(acc_d);
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                cnt_d = cnt_q + CW'(1);
                case (mode_q)
                    MODE_DEC: begin
                        lastStep = (cnt_q == DEC_LAST);
                        for (int i = 0; i < NDIG; i++) begin
                            if (acc_q[4*i +: 4] >= 4'd5) begin
                                dabbled[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
                            end
                        end
                        ovf_d  = ovf_q | dabbled[ACCW-1];
                        acc_d  = {dabbled[ACCW-2:0], work_q[WIDTH-1]};
                        work_d = work_q << 1;
                    end
                    MODE_HEX, MODE_OCT: begin
                        if (mode_q == MODE_HEX) begin
                            lastStep = (cnt_q == HEX_LAST);
                            digit    = work_q[3:0];
                            work_d   = work_q >> 4;
                        end else begin
                            lastStep = (cnt_q == OCT_LAST);
                            digit    = {1'b0, work_q[2:0]};
                            work_d   = work_q >> 3;
                        end
                        for (int i = 0; i < NDIG; i++) begin
                            if (cnt_q == CW'(i)) begin
                                acc_d[4*i +: 4] = digit;
                                placed          = 1'b1;
                            end
                        end
                        if (!placed && digit != 4'd0) begin
                            ovf_d = 1'b1;
                        end
                    end
                    default: begin
                        lastStep = 1'b1;
                    end
                endcase
                if (lastStep) begin
                    ndig_d  = calcNdig(acc_d);
                    state_d = DONE;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_HEX;
            work_q  <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            ndig_q  <= NDW'(1);
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            ndig_q  <= ndig_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_digits = acc_q;
    assign out_neg    = neg_q;
    assign out_ndig   = ndig_q;
    assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_radix_convert_seq.sv
// tb_radix_convert_seq: randomized self-checking bench for radix_convert_seq
// against an arithmetic digit-extraction reference model.
module tb_radix_convert_seq;

    localparam int WIDTH = 32;
    localparam int NDIG  = 11;
    localparam int NDIG4 = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        in_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [43:0] out_digits;
    logic        out_neg;
    logic [3:0]  out_ndig;
    logic        out_ovf;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic        out_valid4;
    logic        out_ready4 = 1'b0;
    logic [15:0] out_digits4;
    logic        out_neg4;
    logic [2:0]  out_ndig4;
    logic        out_ovf4;

    int testsRun  = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    radix_convert_seq #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready), .out_digits(out_digits),
        .out_neg(out_neg), .out_ndig(out_ndig), .out_ovf(out_ovf)
    );

    radix_convert_seq #(.WIDTH(WIDTH), .NDIG(NDIG4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data), .in_mode(in_mode), .in_signed(in_signed),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_digits(out_digits4),
        .out_neg(out_neg4), .out_ndig(out_ndig4), .out_ovf(out_ovf4)
    );

    // Reference: peel digits off the operand value with % and / in the chosen base.
    function automatic void refModel(input logic [1:0] mode, input logic [31:0] data,
                                     input logic sgn, input int nd,
                                     output logic [63:0] dig, output logic neg,
                                     output int ndig, output logic ovf);
        longint unsigned v;
        longint unsigned base;
        longint unsigned r;
        neg  = (mode == 2'b10) && sgn && data[31];
        v    = neg ? ((64'd1 << 32) - {32'd0, data}) : {32'd0, data};
        base = (mode == 2'b10) ? 10 : (mode == 2'b01) ? 8 : 16;
        dig  = '0;
        ndig = 1;
        for (int i = 0; i < nd; i++) begin
            r = v % base;
            dig[4*i +: 4] = r[3:0];
            if (r != 0) ndig = i + 1;
            v = v / base;
        end
        ovf = (v != 0);
    endfunction

    function automatic int expLatency(input logic [1:0] mode);
        case (mode)
            2'b10:   return WIDTH + 1;
            2'b00:   return (WIDTH + 3) / 4 + 1;
            2'b01:   return (WIDTH + 2) / 3 + 1;
            default: return 1;
        endcase
    endfunction

    // One conversion on the NDIG=11 instance with optional backpressure and input noise.
    task automatic runConv(input logic [1:0] mode, input logic [31:0] data, input logic sgn,
                           input int hold, input bit noise, input string name);
        logic [63:0] expDig;
        logic        expNeg;
        int          expNdig;
        logic        expOvf;
        int          lat;
        refModel(mode, data, sgn, NDIG, expDig, expNeg, expNdig, expOvf);

        @(negedge clk);
        testsRun++;
        if (in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL %s idle_ready: got %b, expected 1", name, in_ready);
        end
        in_valid  = 1'b1;
        in_data   = data;
        in_mode   = mode;
        in_signed = sgn;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (noise) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = $urandom;
                in_mode   = 2'($urandom_range(0, 3));
                in_signed = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        testsRun++;
        if (lat !== expLatency(mode)) begin
            failCount++;
            $display("[TB] FAIL %s latency: got %0d, expected %0d", name, lat, expLatency(mode));
        end

        for (int h = 0; h <= hold; h++) begin
            testsRun++;
            if ({out_valid, in_ready, out_digits, out_neg, out_ndig, out_ovf} !==
                {1'b1, 1'b0, expDig[43:0], expNeg, 4'(expNdig), expOvf}) begin
                failCount++;
                $display("[TB] FAIL %s result(hold %0d): got valid=%b ready=%b digits=%h neg=%b ndig=%0d ovf=%b, expected valid=1 ready=0 digits=%h neg=%b ndig=%0d ovf=%b",
                         name, h, out_valid, in_ready, out_digits, out_neg, out_ndig, out_ovf,
                         expDig[43:0], expNeg, expNdig, expOvf);
            end
            if (h < hold) begin
                if (noise) begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_data  = $urandom;
                end
                @(negedge clk);
            end
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        testsRun++;
        if ({out_valid, in_ready, out_digits} !== {1'b0, 1'b1, expDig[43:0]}) begin
            failCount++;
            $display("[TB] FAIL %s after_handshake: got valid=%b ready=%b digits=%h, expected valid=0 ready=1 digits=%h",
                     name, out_valid, in_ready, out_digits, expDig[43:0]);
        end
    endtask

    // One conversion on the NDIG=4 instance, checking truncation and overflow.
    task automatic runConv4(input logic [1:0] mode, input logic [31:0] data, input logic sgn,
                            input string name);
        logic [63:0] expDig;
        logic        expNeg;
        int          expNdig;
        logic        expOvf;
        int          waitCnt;
        refModel(mode, data, sgn, NDIG4, expDig, expNeg, expNdig, expOvf);
        @(negedge clk);
        in_valid4 = 1'b1;
        in_data   = data;
        in_mode   = mode;
        in_signed = sgn;
        @(posedge clk);
        @(negedge clk);
        in_valid4 = 1'b0;
        waitCnt = 0;
        while (out_valid4 !== 1'b1 && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        testsRun++;
        if ({out_valid4, out_digits4, out_neg4, out_ndig4, out_ovf4} !==
            {1'b1, expDig[15:0], expNeg, 3'(expNdig), expOvf}) begin
            failCount++;
            $display("[TB] FAIL %s: got valid=%b digits=%h neg=%b ndig=%0d ovf=%b, expected valid=1 digits=%h neg=%b ndig=%0d ovf=%b",
                     name, out_valid4, out_digits4, out_neg4, out_ndig4, out_ovf4,
                     expDig[15:0], expNeg, expNdig, expOvf);
        end
        out_ready4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready4 = 1'b0;
    endtask

    task automatic checkResetOutputs(input string name);
        testsRun++;
        if ({in_ready, out_valid, out_digits, out_neg, out_ndig, out_ovf} !==
            {1'b1, 1'b0, 44'h0, 1'b0, 4'd1, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL %s: got ready=%b valid=%b digits=%h neg=%b ndig=%0d ovf=%b, expected ready=1 valid=0 digits=0 neg=0 ndig=1 ovf=0",
                     name, in_ready, out_valid, out_digits, out_neg, out_ndig, out_ovf);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset_main");
        testsRun++;
        if ({in_ready4, out_valid4, out_digits4, out_ndig4, out_ovf4} !== {1'b1, 1'b0, 16'h0, 3'd1, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL reset_ndig4: got ready=%b valid=%b digits=%h ndig=%0d ovf=%b, expected 1 0 0 1 0",
                     in_ready4, out_valid4, out_digits4, out_ndig4, out_ovf4);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        runConv(2'b10, 32'd255,        1'b0, 0, 1'b0, "dec_255");
        runConv(2'b10, 32'hFFFFFFFF,   1'b1, 0, 1'b0, "dec_minus1");
        runConv(2'b10, 32'h80000000,   1'b1, 0, 1'b0, "dec_most_negative");
        runConv(2'b10, 32'hFFFFFFFF,   1'b0, 0, 1'b0, "dec_max_unsigned");
        runConv(2'b01, 32'd15,         1'b1, 0, 1'b0, "oct_15");
        runConv(2'b00, 32'hDEADBEEF,   1'b1, 0, 1'b0, "hex_deadbeef");
        runConv(2'b11, 32'h89ABCDEF,   1'b0, 0, 1'b0, "raw_89abcdef");
        runConv(2'b01, 32'hFFFFFFFF,   1'b0, 0, 1'b0, "oct_all_ones");
    endtask

    task automatic test_ndig4();
        runConv4(2'b10, 32'd123456,     1'b0, "ndig4_dec_123456");
        runConv4(2'b11, 32'h00012345,   1'b0, "ndig4_raw_12345");
        runConv4(2'b00, 32'h0000BEEF,   1'b0, "ndig4_hex_fit");
        runConv4(2'b01, 32'd4095,       1'b0, "ndig4_oct_fit");
        runConv4(2'b01, 32'd4096,       1'b0, "ndig4_oct_ovf");
        runConv4(2'b10, 32'h80000000,   1'b1, "ndig4_dec_neg");
    endtask

    task automatic test_backpressure();
        runConv(2'b10, 32'd987654321, 1'b0, 10, 1'b1, "backpressure_dec");
        runConv(2'b00, 32'h00C0FFEE,  1'b0, 10, 1'b1, "backpressure_hex");
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 32'h9ABCDEF1;
        in_mode   = 2'b10;
        in_signed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        runConv(2'b10, 32'd0, 1'b0, 0, 1'b0, "zero_after_reset");
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < 4; m++) begin
            runConv(2'(m), 32'd0, 1'b1, 0, 1'b0, "zero_each_mode");
        end
    endtask

    task automatic test_random();
        logic [31:0] data;
        for (int i = 0; i < 40; i++) begin
            data = (i % 3 == 0) ? 32'($urandom_range(0, 999)) : $urandom;
            runConv(2'($urandom_range(0, 3)), data, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), 1'(i % 2), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ndig4();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, tests run %0d", testsRun);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
